seg_scan_arbiter: RTL and testbench



---
 rtl/seg_scan_arbiter_pkg.sv | 7 +
 rtl/seg_scan_arbiter_hex.sv | 9 +
 rtl/seg_scan_arbiter.sv | 95 +++++++++
 tb/tb_seg_scan_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_arbiter_pkg.sv
// seg_pkg: shared blanking constants and state types for the seven-segment scan arbiter
package seg_pkg;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  typedef enum logic {BLANK, DRIVE} scan_e;
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} own_e;
endpackage

// File: rtl/seg_scan_arbiter_hex.sv
// hexEncode: active-low seven-segment glyph for one hex nibble, dp off
module hexEncode (
  input  logic [3:0] hex,
  output logic [7:0] seg
);
  localparam logic [127:0] LUT = {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h98, 8'h80,
                                  8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
  always_comb seg = LUT[{hex, 3'b000} +: 8];
endmodule

// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter: two-client display arbiter with blanked 4-digit scan; ownership and data change only at frame boundaries
module seg_scan_arbiter
  import seg_pkg::*;
#(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 1000,
  parameter int HOLD_SCANS  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [15:0] data_a,
  input  logic [3:0]  mask_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  input  logic [3:0]  mask_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [3:0]  D0_AN,
  output logic [7:0]  D0_SEG,
  output logic        frame_done
);
  localparam int TMAX = DIGIT_TICKS > BLANK_TICKS ? DIGIT_TICKS : BLANK_TICKS;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam int HW = $clog2(HOLD_SCANS + 1);
  localparam logic [TW-1:0] DLAST = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] BLAST = TW'(BLANK_TICKS - 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_SCANS);
  scan_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [TW-1:0] tick_q, tick_d;
  logic tick_end, lit;
  own_e own_q, own_d, own_n;
  logic ptr_b_q, ptr_b_d;
  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic [15:0] data_q, data_d;
  logic [3:0] mask_q, mask_d;
  logic [7:0] glyph;
  hexEncode u_hex (.hex(data_q[{idx_q, 2'b00} +: 4]), .seg(glyph));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK;
      idx_q   <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
    end
  end
  always_comb begin
    tick_end = tick_q == (state_q == DRIVE ? DLAST : BLAST);
    state_d  = tick_end ? (state_q == DRIVE ? BLANK : DRIVE) : state_q;
    tick_d   = tick_end ? '0 : tick_q + 1'b1;
    idx_d    = tick_end && state_q == DRIVE ? idx_q + 2'd1 : idx_q;
  end
  always_comb begin
    lit        = state_q == DRIVE && own_q != IDLE && mask_q[idx_q];
    D0_AN      = lit ? ~(4'b0001 << idx_q) : AN_OFF;
    D0_SEG     = lit ? glyph : SEG_OFF;
    frame_done = state_q == DRIVE && tick_end && idx_q == 2'd3;
    gnt_a      = own_q == OWN_A;
    gnt_b      = own_q == OWN_B;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_q   <= IDLE;
      ptr_b_q <= 1'b0;
      hold_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      own_q   <= own_d;
      ptr_b_q <= ptr_b_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end
  // hold_inc includes the frame completing now, so an owner keeps at least HOLD_SCANS frames
  always_comb begin
    hold_inc = hold_q == HMAX ? HMAX : hold_q + 1'b1;
    case (own_q)
      IDLE:    own_n = req_a && (!req_b || !ptr_b_q) ? OWN_A : req_b ? OWN_B : IDLE;
      OWN_A:   own_n = !req_a ? (req_b ? OWN_B : IDLE) : req_b && hold_inc == HMAX ? OWN_B : OWN_A;
      OWN_B:   own_n = !req_b ? (req_a ? OWN_A : IDLE) : req_a && hold_inc == HMAX ? OWN_A : OWN_B;
      default: own_n = IDLE;
    endcase
    own_d   = frame_done ? own_n : own_q;
    hold_d  = !frame_done ? hold_q : (own_n != own_q || own_n == IDLE) ? '0 : hold_inc;
    ptr_b_d = frame_done && own_n == OWN_A ? 1'b1 : frame_done && own_n == OWN_B ? 1'b0 : ptr_b_q;
    data_d  = !frame_done ? data_q : own_n == OWN_A ? data_a : own_n == OWN_B ? data_b : 16'h0;
    mask_d  = !frame_done ? mask_q : own_n == OWN_A ? mask_a : own_n == OWN_B ? mask_b : 4'h0;
  end
endmodule

// File: tb/tb_seg_scan_arbiter.sv
// tb_seg_scan_arbiter: table, hand-sequence and random checks against a frame-level model of the scan arbiter
module tb_seg_scan_arbiter;
  localparam int HOLD = 2;
  localparam int FRAME = 24;
  localparam logic [7:0] GLY [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_a = 1'b0, req_b = 1'b0;
  logic [15:0] data_a = '0, data_b = '0;
  logic [3:0] mask_a = '0, mask_b = '0;
  logic gnt_a, gnt_b, frame_done;
  logic [3:0] D0_AN;
  logic [7:0] D0_SEG;
  int n_chk = 0, n_fail = 0;
  seg_scan_arbiter #(.DIGIT_TICKS(4), .BLANK_TICKS(2), .HOLD_SCANS(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .data_a(data_a), .mask_a(mask_a),
    .req_b(req_b), .data_b(data_b), .mask_b(mask_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .D0_AN(D0_AN), .D0_SEG(D0_SEG), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 25) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: owner 0=none 1=A 2=B; frames = frames completed under current owner
  int cyc, m_own, m_frames, nx;
  bit m_pref_b;
  logic [15:0] m_data;
  logic [3:0] m_mask;
  function automatic int nxt_owner(int own, int frames, bit pref_b, bit ra, bit rb);
    bit mine, theirs;
    if (own == 0) return ra && rb ? (pref_b ? 2 : 1) : ra ? 1 : rb ? 2 : 0;
    mine = own == 1 ? ra : rb;
    theirs = own == 1 ? rb : ra;
    if (!mine) return theirs ? 3 - own : 0;
    return theirs && frames + 1 >= HOLD ? 3 - own : own;
  endfunction
  always_comb nx = nxt_owner(m_own, m_frames, m_pref_b, req_a, req_b);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0; m_own <= 0; m_frames <= 0; m_pref_b <= 1'b0; m_data <= '0; m_mask <= '0;
    end else begin
      cyc <= cyc + 1;
      if (cyc % FRAME == FRAME - 1) begin
        m_own <= nx;
        m_frames <= nx == m_own && nx != 0 ? m_frames + 1 : 0;
        if (nx != 0) m_pref_b <= nx == 1;
        m_data <= nx == 1 ? data_a : nx == 2 ? data_b : 16'h0;
        m_mask <= nx == 1 ? mask_a : nx == 2 ? mask_b : 4'h0;
      end
    end
  end
  int pos, dig;
  logic e_lit, e_fd;
  logic [3:0] e_an;
  logic [7:0] e_seg;
  always_comb begin
    pos   = cyc % FRAME;
    dig   = pos / 6;
    e_lit = pos % 6 >= 2 && m_own != 0 && m_mask[dig];
    e_an  = e_lit ? ~(4'b0001 << dig) : 4'hF;
    e_seg = e_lit ? GLY[m_data[dig*4 +: 4]] : 8'hFF;
    e_fd  = pos == FRAME - 1;
  end
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_an", 16'(D0_AN), 16'(e_an));
      chk("model_seg", 16'(D0_SEG), 16'(e_seg));
      chk("model_fd", 16'(frame_done), 16'(e_fd));
      chk("model_gnt", {14'b0, gnt_a, gnt_b}, {14'b0, m_own == 1, m_own == 2});
    end
  end
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  // waits for frame_done (bounded), then moves to the first cycle of the next frame
  task automatic wait_fd(output int n);
    bit seen = 1'b0;
    n = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      seen = frame_done;
    end
    if (!seen) chk("fd_timeout", 16'd0, 16'd1);
    step(1);
  endtask
  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0; mask_a = '0; mask_b = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  typedef struct {
    logic ra, rb;
    logic [15:0] da, db;
    logic [3:0] ma, mb;
    logic ga, gb;
  } vec_t;
  vec_t tbl [10];
  localparam logic [3:0] SCAN_AN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [7:0] SCAN_SEG [4] = '{8'h8E, 8'hA4, 8'h88, 8'hF9};
  int n;
  initial begin
    tbl[0] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'h0123, 16'h4567, 4'hF, 4'hF, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 16'h89AB, 16'hCDEF, 4'hA, 4'h5, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 16'hBEEF, 16'hDEAD, 4'hF, 4'h3, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 16'h1111, 16'hC0DE, 4'h1, 4'hE, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 16'h2222, 16'h3333, 4'hF, 4'hF, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 16'hFACE, 16'h0F0F, 4'h7, 4'hF, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 16'h4444, 16'h5555, 4'hF, 4'hF, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 16'h6666, 16'h9876, 4'hF, 4'hB, 1'b0, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 16'hE5D4, 16'h7777, 4'hF, 4'hF, 1'b1, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 16'(D0_AN), 16'hF);
    chk("rst_seg", 16'(D0_SEG), 16'hFF);
    chk("rst_fd", 16'(frame_done), 16'h0);
    chk("rst_gnt", {14'b0, gnt_a, gnt_b}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fd(n);
    chk("idle_first_fd", 16'(n), 16'd23);
    wait_fd(n);
    chk("idle_fd_period", 16'(n), 16'd24);
    chk("idle_gnt", {14'b0, gnt_a, gnt_b}, 16'h0);
    reset_dut();
    req_a = 1'b1; data_a = 16'h1A2F; mask_a = 4'hF;
    wait_fd(n);
    chk("single_gnt_a", 16'(gnt_a), 16'h1);
    for (int d = 0; d < 4; d++) begin
      step(2);
      chk("scan_an", 16'(D0_AN), 16'(SCAN_AN[d]));
      chk("scan_seg", 16'(D0_SEG), 16'(SCAN_SEG[d]));
      step(4);
    end
    step(3);
    data_a = 16'h0000;
    step(5);
    chk("midframe_hold_seg", 16'(D0_SEG), 16'hA4);
    step(24);
    chk("midframe_next_seg", 16'(D0_SEG), 16'hC0);
    mask_a = 4'b0101; data_a = 16'h1A2F;
    step(24);
    chk("mask_d1_an", 16'(D0_AN), 16'hF);
    step(6);
    chk("mask_d2_an", 16'(D0_AN), 16'hB);
    chk("mask_d2_seg", 16'(D0_SEG), 16'h88);
    step(6);
    chk("mask_d3_an", 16'(D0_AN), 16'hF);
    chk("mask_d3_seg", 16'(D0_SEG), 16'hFF);
    reset_dut();
    req_a = 1'b1; data_a = 16'h4321; mask_a = 4'hF; data_b = 16'h8765; mask_b = 4'hF;
    wait_fd(n);
    chk("hold_gnt_a", 16'(gnt_a), 16'h1);
    req_b = 1'b1;
    wait_fd(n);
    chk("hold_keep_a", {14'b0, gnt_a, gnt_b}, 16'h2);
    wait_fd(n);
    chk("hold_rotate_b", {14'b0, gnt_a, gnt_b}, 16'h1);
    reset_dut();
    req_a = 1'b1; req_b = 1'b1; data_a = 16'hAAAA; data_b = 16'hBBBB; mask_a = 4'hF; mask_b = 4'hF;
    wait_fd(n);
    chk("simul_first_a", {14'b0, gnt_a, gnt_b}, 16'h2);
    req_a = 1'b0;
    wait_fd(n);
    chk("simul_drop_b", {14'b0, gnt_a, gnt_b}, 16'h1);
    req_a = 1'b1;
    wait_fd(n);
    chk("simul_b_hold", {14'b0, gnt_a, gnt_b}, 16'h1);
    wait_fd(n);
    chk("simul_back_a", {14'b0, gnt_a, gnt_b}, 16'h2);
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      req_a = tbl[i].ra; req_b = tbl[i].rb;
      data_a = tbl[i].da; data_b = tbl[i].db; mask_a = tbl[i].ma; mask_b = tbl[i].mb;
      wait_fd(n);
      chk($sformatf("tbl%0d_gnt", i), {14'b0, gnt_a, gnt_b}, {14'b0, tbl[i].ga, tbl[i].gb});
    end
    step(3);
    chk("pre_rst_an", 16'(D0_AN), 16'hE);
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", 16'(D0_AN), 16'hF);
    chk("async_rst_seg", 16'(D0_SEG), 16'hFF);
    chk("async_rst_gnt", {14'b0, gnt_a, gnt_b}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) req_a = ~req_a;
      if ($urandom_range(0, 15) == 0) req_b = ~req_b;
      if ($urandom_range(0, 7) == 0) begin
        data_a = 16'($urandom); data_b = 16'($urandom);
        mask_a = 4'($urandom); mask_b = 4'($urandom);
      end
    end
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
